// File: rtl/am_insert_ctrl.sv
// rtl/am_insert_ctrl.sv - alignment-marker insertion slot controller
//
// Walks a lane counter (0..N_LANES-1) and a round counter (0..AM_PERIOD-1).
// Round 0 of every marker period is an AM round: each lane slot carries an
// alignment marker and advances every cycle. Other rounds are DATA rounds:
// a lane slot advances only when upstream offers a block (i_valid) while the
// slot is open (o_ready). Disabling takes effect only at a lane wrap, so a
// started round always completes.
//
// Ports:
//   clk          rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_enable     run request, sampled at lane wrap (and in IDLE)
//   i_valid      upstream has a data block this cycle
//   o_ready      current slot is a data slot and accepts a block
//   o_am_insert  current slot carries an alignment marker
//   o_lane_id    binary lane id of the current slot
//   o_lane_mask  one-hot lane select of the current slot, zero in IDLE

module am_insert_ctrl #(
    parameter int N_LANES   = 20,
    parameter int ID_LEN    = $clog2(N_LANES),
    parameter int AM_PERIOD = 16384
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic               i_valid,
    output logic               o_ready,
    output logic               o_am_insert,
    output logic [ID_LEN-1:0]  o_lane_id,
    output logic [N_LANES-1:0] o_lane_mask
);

    localparam int RND_W = (AM_PERIOD > 2) ? $clog2(AM_PERIOD) : 1;
    localparam logic [ID_LEN-1:0] LANE_LAST = ID_LEN'(N_LANES - 1);
    localparam logic [RND_W-1:0]  RND_LAST  = RND_W'(AM_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AM   = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [ID_LEN-1:0]  lane_q, lane_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic               advance;
    logic               ready_q, am_q;
    logic [N_LANES-1:0] mask_q, mask_d;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        round_d = round_q;
        advance = 1'b0;
        case (state_q)
            ST_IDLE: begin
                lane_d  = '0;
                round_d = '0;
                if (i_enable) begin
                    state_d = ST_AM;
                end
            end
            ST_AM, ST_DATA: begin
                // Marker slots never wait for upstream; data slots need a block.
                advance = (state_q == ST_AM) || i_valid;
                if (advance) begin
                    // >= keeps a non-power-of-two lane count from escaping its range.
                    if (lane_q >= LANE_LAST) begin
                        lane_d  = '0;
                        round_d = (round_q >= RND_LAST) ? '0 : round_q + 1'b1;
                        if (!i_enable) begin
                            state_d = ST_IDLE;
                            round_d = '0;
                        end else if (round_d == '0) begin
                            state_d = ST_AM;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                lane_d  = '0;
                round_d = '0;
            end
        endcase
    end

    always_comb begin
        mask_d = '0;
        for (int i = 0; i < N_LANES; i++) begin
            mask_d[i] = (state_d != ST_IDLE) && (lane_d == ID_LEN'(i));
        end
    end

    // Slot outputs are registered from the next-state decode so they line up
    // with the state they describe.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            lane_q  <= '0;
            round_q <= '0;
            ready_q <= 1'b0;
            am_q    <= 1'b0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            round_q <= round_d;
            ready_q <= (state_d == ST_DATA);
            am_q    <= (state_d == ST_AM);
            mask_q  <= mask_d;
        end
    end

    assign o_ready     = ready_q;
    assign o_am_insert = am_q;
    assign o_lane_id   = lane_q;
    assign o_lane_mask = mask_q;

endmodule

// File: tb/tb_am_insert_ctrl.sv
// tb/tb_am_insert_ctrl.sv - scoreboard bench for am_insert_ctrl

module tb_am_insert_ctrl;

    localparam int NL  = 4;
    localparam int PER = 3;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic       i_enable = 1'b0;
    logic       i_valid = 1'b0;
    logic       o_ready;
    logic       o_am_insert;
    logic [1:0] o_lane_id;
    logic [3:0] o_lane_mask;

    logic        d_rst_n;
    logic        d_en = 1'b0;
    logic        d_val = 1'b0;
    logic        d_ready;
    logic        d_am;
    logic [4:0]  d_id;
    logic [19:0] d_mask;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit def_done = 1'b0;

    am_insert_ctrl #(.N_LANES(NL), .AM_PERIOD(PER)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_valid(i_valid),
        .o_ready(o_ready), .o_am_insert(o_am_insert),
        .o_lane_id(o_lane_id), .o_lane_mask(o_lane_mask)
    );

    am_insert_ctrl dut_def (
        .clk(clk), .i_rst_n(d_rst_n), .i_enable(d_en), .i_valid(d_val),
        .o_ready(d_ready), .o_am_insert(d_am),
        .o_lane_id(d_id), .o_lane_mask(d_mask)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        int         due;
        logic       am;
        logic       rdy;
        logic [1:0] id;
        logic [3:0] mask;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: count of slots consumed since the current run began.
    bit m_run = 1'b0;
    int m_slots = 0;

    function automatic bit m_is_am();
        return ((m_slots / NL) % PER) == 0;
    endfunction

    task automatic model_edge(input logic rst, input logic en, input logic val);
        if (!rst) begin
            m_run = 1'b0;
            m_slots = 0;
        end else if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_slots = 0;
            end
        end else if (m_is_am() || val) begin
            if ((m_slots % NL) == NL - 1 && !en) m_run = 1'b0;
            m_slots++;
        end
    endtask

    task automatic push_exp(input int due);
        exp_t e;
        e.due = due;
        if (m_run) begin
            e.id   = 2'(m_slots % NL);
            e.am   = m_is_am();
            e.rdy  = !e.am;
            e.mask = 4'd1 << e.id;
        end else begin
            e.id = 2'd0; e.am = 1'b0; e.rdy = 1'b0; e.mask = 4'd0;
        end
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; expectation is for the next one.
    task automatic drive(input logic rst, input logic en, input logic val);
        @(negedge clk);
        i_rst_n = rst;
        i_enable = en;
        i_valid = val;
        model_edge(rst, en, val);
        push_exp(cyc + 1);
    endtask

    // Reset asserted between edges, checked before any clock arrives.
    task automatic pulse_reset(input int hold);
        @(posedge clk);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("rst_async", {o_am_insert, o_ready, o_lane_id, o_lane_mask}, 0);
        exp_q.delete();
        m_run = 1'b0;
        m_slots = 0;
        push_exp(cyc);
        repeat (hold) drive(1'b0, 1'($urandom), 1'($urandom));
        drive(1'b1, 1'b1, 1'($urandom));
    endtask

    task automatic run_until(input string name, input logic want_am, input int lane, input int bound);
        bit hit = 1'b0;
        for (int i = 0; i <= bound && !hit; i++) begin
            if (m_run && m_is_am() == want_am && (m_slots % NL) == lane) hit = 1'b1;
            else if (i < bound) drive(1'b1, 1'b1, 1'b1);
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s: target slot not reached within %0d cycles", name, bound);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (mon_e.due != cyc || o_am_insert !== mon_e.am || o_ready !== mon_e.rdy ||
                o_lane_id !== mon_e.id || o_lane_mask !== mon_e.mask) begin
                errors++;
                $display("FAIL scoreboard cyc=%0d: got am=%b rdy=%b id=%0d mask=%b, expected am=%b rdy=%b id=%0d mask=%b",
                         cyc, o_am_insert, o_ready, o_lane_id, o_lane_mask,
                         mon_e.am, mon_e.rdy, mon_e.id, mon_e.mask);
            end
        end
    end

    initial begin
        d_rst_n = 1'b1;
        #1 d_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        d_rst_n = 1'b1;
        d_en = 1'b1;
        d_val = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 60; k++) begin
            logic [19:0] em;
            @(negedge clk);
            em = 20'd1 << (k % 20);
            chk($sformatf("def_slot%0d", k), {d_am, d_ready, d_id, d_mask},
                {(k < 20), (k >= 20), 5'(k % 20), em});
        end
        def_done = 1'b1;
    end

    initial begin
        i_rst_n = 1'b1;
        #1 i_rst_n = 1'b0;
        i_enable = 1'($urandom);
        i_valid = 1'($urandom);
        #1 chk("rst_initial", {o_am_insert, o_ready, o_lane_id, o_lane_mask}, 0);
        repeat (4) drive(1'b0, 1'($urandom), 1'($urandom));
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);

        // Continuous enable and valid: AM round, two data rounds, AM again.
        repeat (30) drive(1'b1, 1'b1, 1'b1);

        // Data stalls at lane 2.
        run_until("reach_data_l2", 1'b0, 2, 40);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        chk("hold_a", {o_ready, o_lane_id, o_lane_mask}, {1'b1, 2'd2, 4'b0100});
        drive(1'b1, 1'b1, 1'b0);
        chk("hold_b", {o_ready, o_lane_id, o_lane_mask}, {1'b1, 2'd2, 4'b0100});
        drive(1'b1, 1'b1, 1'b1);
        chk("hold_c", {o_ready, o_lane_id, o_lane_mask}, {1'b1, 2'd2, 4'b0100});

        // Disable mid-round at lane 1: round completes, then idle.
        run_until("reach_data_l1", 1'b0, 1, 40);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        chk("stop_l3", {o_ready, o_lane_id, o_lane_mask}, {1'b1, 2'd3, 4'b1000});
        drive(1'b1, 1'b0, 1'b1);
        chk("stop_idle", {o_am_insert, o_ready, o_lane_mask}, 0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        chk("restart_am", {o_am_insert, o_ready, o_lane_id, o_lane_mask}, {1'b1, 1'b0, 2'd0, 4'b0001});

        // Reset in the middle of an AM round.
        run_until("reach_am_l2", 1'b1, 2, 60);
        pulse_reset(2);
        drive(1'b1, 1'b1, 1'b1);
        chk("rst_restart", {o_am_insert, o_lane_id, o_lane_mask}, {1'b1, 2'd0, 4'b0001});
        repeat (6) drive(1'b1, 1'b1, 1'b1);

        // Random traffic with occasional enable drops and resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset($urandom_range(0, 2));
            else drive(1'b1, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0));
        end

        repeat (2) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        for (int w = 0; w < 200 && !def_done; w++) @(negedge clk);
        if (!def_done) begin
            checks++;
            errors++;
            $display("FAIL def_timeout: default-parameter sequence did not finish");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
